// File: rtl/alu_pkg.sv
// alu_pkg: op encodings, FSM states and op-field width shared by alu_mc and its bench.
package alu_pkg;
    localparam int ALU_OP_W = 5;
    typedef enum logic [ALU_OP_W-1:0] {
        OP_SLL  = 5'h00, OP_SRL  = 5'h01, OP_MUL   = 5'h02, OP_MULU = 5'h03,
        OP_DIV  = 5'h04, OP_DIVU = 5'h05, OP_ADD   = 5'h06, OP_ADDU = 5'h07,
        OP_SUB  = 5'h08, OP_SUBU = 5'h09, OP_AND   = 5'h0A, OP_OR   = 5'h0B,
        OP_XOR  = 5'h0C, OP_NOR  = 5'h0D, OP_SLT   = 5'h0E, OP_SLTU = 5'h0F,
        OP_PASSB = 5'h10, OP_SRA = 5'h11
    } alu_op_e;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} alu_state_e;
endpackage

// File: rtl/alu_mc_div_iter.sv
// div_iter: restoring unsigned divider, one quotient bit per clock after start.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] d;
    logic [CW-1:0] cnt;
    logic [WIDTH:0] sh, trial;
    assign sh = {rem, quot[WIDTH-1]};
    assign trial = sh - {1'b0, d};
    // quot doubles as the dividend shift register; its freed low bits collect quotient bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quot <= '0;
            rem <= '0;
            d <= '0;
            cnt <= '0;
            done <= 1'b0;
        end else if (start) begin
            quot <= a;
            rem <= '0;
            d <= b;
            cnt <= CW'(WIDTH);
            done <= 1'b0;
        end else if (cnt != '0) begin
            rem <= trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], ~trial[WIDTH]};
            cnt <= cnt - CW'(1);
            done <= cnt == CW'(1);
        end
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle handshaked EXE-stage ALU with fixed-latency MUL and iterative DIV.
// Define ALU_DIV_EN to build the divider; otherwise DIV/DIVU are reported as undefined ops.
module alu_mc import alu_pkg::*; #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result,
    output logic [WIDTH-1:0]    hi,
    output logic                zero,
    output logic                ovf,
    output logic                err
);
    localparam int SH_W = $clog2(WIDTH);
    localparam int CW = $clog2(MUL_LAT + 1);
    alu_state_e state, nxt;
    logic [ALU_OP_W-1:0] op_r;
    logic [WIDTH-1:0] a_r, b_r, sum, dif, s_res, l_res, l_hi;
    logic [2*WIDTH-1:0] mul;
    logic [CW-1:0] cnt;
    logic accept, long_op, long_done, m_sx, s_ovf, s_err, l_err;

    assign accept = in_valid & in_ready;
    assign in_ready = (state == IDLE) | (state == DONE & out_ready);
    assign out_valid = state == DONE;
    assign sum = a + b;
    assign dif = a - b;
    // sign-extending both factors to 2*WIDTH makes one unsigned multiplier serve MUL and MULU
    assign m_sx = op_r == OP_MUL;
    assign mul = {{WIDTH{m_sx & a_r[WIDTH-1]}}, a_r} * {{WIDTH{m_sx & b_r[WIDTH-1]}}, b_r};

`ifdef ALU_DIV_EN
    logic [WIDTH-1:0] quot, rem, q_fix, r_fix;
    logic div_done, div_s, is_mul;
    assign long_op = op == OP_MUL || op == OP_MULU || op == OP_DIV || op == OP_DIVU;
    assign div_s = op == OP_DIV;
    assign is_mul = op_r == OP_MUL || op_r == OP_MULU;
    div_iter #(.WIDTH(WIDTH)) u_div (
        .clk(clk), .rst(rst),
        .start(accept && (op == OP_DIV || op == OP_DIVU)),
        .a(div_s && a[WIDTH-1] ? -a : a),
        .b(div_s && b[WIDTH-1] ? -b : b),
        .done(div_done), .quot(quot), .rem(rem)
    );
    assign q_fix = op_r == OP_DIV && (a_r[WIDTH-1] ^ b_r[WIDTH-1]) ? -quot : quot;
    assign r_fix = op_r == OP_DIV && a_r[WIDTH-1] ? -rem : rem;
    assign long_done = is_mul ? cnt == '0 : div_done;
    assign l_res = is_mul ? mul[WIDTH-1:0] : b_r == '0 ? '1 : q_fix;
    assign l_hi = is_mul ? mul[2*WIDTH-1:WIDTH] : b_r == '0 ? a_r : r_fix;
    assign l_err = !is_mul && b_r == '0;
`else
    assign long_op = op == OP_MUL || op == OP_MULU;
    assign long_done = cnt == '0;
    assign l_res = mul[WIDTH-1:0];
    assign l_hi = mul[2*WIDTH-1:WIDTH];
    assign l_err = 1'b0;
`endif

    always_comb begin
        s_res = '0;
        s_ovf = 1'b0;
        s_err = 1'b0;
        case (op)
            OP_SLL:   s_res = a << b[SH_W-1:0];
            OP_SRL:   s_res = a >> b[SH_W-1:0];
            OP_SRA:   s_res = $signed(a) >>> b[SH_W-1:0];
            OP_ADD: begin
                s_res = sum;
                s_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADDU:  s_res = sum;
            OP_SUB: begin
                s_res = dif;
                s_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUBU:  s_res = dif;
            OP_AND:   s_res = a & b;
            OP_OR:    s_res = a | b;
            OP_XOR:   s_res = a ^ b;
            OP_NOR:   s_res = ~(a | b);
            OP_SLT:   s_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU:  s_res = {{(WIDTH-1){1'b0}}, a < b};
            OP_PASSB: s_res = b;
            default:  s_err = 1'b1;
        endcase
    end

    always_comb begin
        nxt = state;
        if (accept) nxt = long_op ? BUSY : DONE;
        else if (state == BUSY && long_done) nxt = DONE;
        else if (state == DONE && out_ready) nxt = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r <= '0;
            a_r <= '0;
            b_r <= '0;
            cnt <= '0;
            result <= '0;
            hi <= '0;
            zero <= 1'b0;
            ovf <= 1'b0;
            err <= 1'b0;
        end else if (accept) begin
            op_r <= op;
            a_r <= a;
            b_r <= b;
            cnt <= CW'(MUL_LAT - 1);
            zero <= a == b;
            if (!long_op) begin
                result <= s_res;
                hi <= '0;
                ovf <= s_ovf;
                err <= s_err;
            end
        end else if (state == BUSY) begin
            cnt <= cnt - CW'(1);
            if (long_done) begin
                result <= l_res;
                hi <= l_hi;
                ovf <= 1'b0;
                err <= l_err;
            end
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc; expectations follow ALU_DIV_EN.
module tb_alu_mc;
    localparam int W = 32;
    localparam int ML = 3;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic [4:0] op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic in_ready, out_valid, zero, ovf, err;
    logic [W-1:0] result, hi;
    int n_cmp = 0, n_bad = 0, lat, cnt;
    logic [4:0] t_op [8] = '{5'h06, 5'h08, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h10};
    logic [31:0] t_a [8] = '{32'd1, 32'd5, 32'hF0F0, 32'hF0F0, 32'hFF, 32'h0, 32'hFFFFFFFF, 32'h0};
    logic [31:0] t_b [8] = '{32'd2, 32'd7, 32'h0FF0, 32'h0F0F, 32'h0F, 32'h0, 32'd1, 32'h12345678};
    logic [31:0] t_r [8] = '{32'd3, 32'hFFFFFFFE, 32'h00F0, 32'hFFFF, 32'hF0, 32'hFFFFFFFF, 32'd1, 32'h12345678};

    alu_mc #(.WIDTH(W), .MUL_LAT(ML)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .hi(hi), .zero(zero), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y, output int l);
        int n = 0;
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        op = 5'h1F;
        a = '1;
        b = '1;
        while (!out_valid && n < 200) begin
            step();
            n++;
        end
        l = n + 1;
    endtask

    initial begin
        step();
        step();
        chk("rst_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_hi", hi, 0);
        chk("rst_flags", {zero, ovf, err}, 0);
        rst = 1'b0;
        step();
        chk("rst_ready", in_ready, 1);

        run(5'h06, 32'h7FFFFFFF, 32'd1, lat);
        chk("add_res", result, 32'h80000000);
        chk("add_ovf", ovf, 1);
        chk("add_err", err, 0);
        chk("add_lat", lat, 1);
        run(5'h07, 32'h7FFFFFFF, 32'd1, lat);
        chk("addu_res", result, 32'h80000000);
        chk("addu_ovf", ovf, 0);
        run(5'h08, 32'h80000000, 32'd1, lat);
        chk("sub_res", result, 32'h7FFFFFFF);
        chk("sub_ovf", ovf, 1);
        run(5'h08, 32'd5, 32'd5, lat);
        chk("sub_zero", zero, 1);
        chk("sub_zres", result, 0);

        run(5'h02, 32'hFFFFFFFF, 32'd2, lat);
        chk("mul_res", result, 32'hFFFFFFFE);
        chk("mul_hi", hi, 32'hFFFFFFFF);
        chk("mul_lat", lat, ML + 1);
        chk("mul_zero", zero, 0);
        run(5'h03, 32'hFFFFFFFF, 32'd2, lat);
        chk("mulu_res", result, 32'hFFFFFFFE);
        chk("mulu_hi", hi, 32'h00000001);
        chk("mulu_lat", lat, ML + 1);

`ifdef ALU_DIV_EN
        run(5'h04, 32'hFFFFFFF9, 32'd2, lat);
        chk("div_res", result, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);
        chk("div_err", err, 0);
        chk("div_lat", lat, W + 2);
        run(5'h05, 32'd7, 32'd0, lat);
        chk("divu0_res", result, 32'hFFFFFFFF);
        chk("divu0_hi", hi, 32'd7);
        chk("divu0_err", err, 1);
        chk("divu0_lat", lat, W + 2);
        run(5'h04, 32'h80000000, 32'hFFFFFFFF, lat);
        chk("divmin_res", result, 32'h80000000);
        chk("divmin_hi", hi, 0);
        chk("divmin_err", err, 0);
        run(5'h05, 32'd100, 32'd7, lat);
        chk("divu_res", result, 32'd14);
        chk("divu_hi", hi, 32'd2);
`else
        run(5'h05, 32'd7, 32'd0, lat);
        chk("divu0_res", result, 0);
        chk("divu0_hi", hi, 0);
        chk("divu0_err", err, 1);
        chk("divu0_lat", lat, 1);
        run(5'h04, 32'hFFFFFFF9, 32'd2, lat);
        chk("div_err", err, 1);
        chk("div_lat", lat, 1);
`endif

        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = t_op[i];
            a = t_a[i];
            b = t_b[i];
            step();
            chk($sformatf("b2b_res%0d", i), result, t_r[i]);
            chk($sformatf("b2b_valid%0d", i), out_valid, 1);
        end
        op = 5'h06;
        a = 32'd9;
        b = 32'd9;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("hold_res%0d", i), result, 32'h12345678);
            chk($sformatf("hold_valid%0d", i), out_valid, 1);
            chk($sformatf("hold_ready%0d", i), in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        chk("resume_res", result, 32'd18);
        in_valid = 1'b0;
        step();

        op = 5'h04;
        a = 32'd100;
        b = 32'd3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_result", result, 0);
        chk("abort_hi", hi, 0);
        chk("abort_flags", {zero, ovf, err}, 0);
        step();
        rst = 1'b0;
        run(5'h06, 32'd2, 32'd3, lat);
        chk("post_res", result, 32'd5);
        chk("post_hi", hi, 0);
        chk("post_lat", lat, 1);
        cnt = 0;
        repeat (W + 8) begin
            step();
            if (out_valid) cnt++;
        end
        chk("no_stale", cnt, 0);

        run(5'h11, 32'h80000000, 32'd4, lat);
        chk("sra_res", result, 32'hF8000000);
        run(5'h01, 32'h80000000, 32'd4, lat);
        chk("srl_res", result, 32'h08000000);
        run(5'h00, 32'd1, 32'h0000003F, lat);
        chk("sll_res", result, 32'h80000000);
        run(5'h15, 32'd5, 32'd6, lat);
        chk("undef_err", err, 1);
        chk("undef_res", result, 0);
        chk("undef_hi", hi, 0);
        chk("undef_lat", lat, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
